// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage sequencer.
// The exception redirect level is only built when FETCH_CTRL_EXC_EN is defined.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    // Numeric order doubles as redirect priority, so a plain compare picks the winner.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_JMP  = 2'd1,
        SRC_BR   = 2'd2,
        SRC_EXC  = 2'd3
    } redir_src_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;

    // A new request replaces an older one of equal or lower priority (newest wins on a tie).
    function automatic logic takes_over(input logic [1:0] new_src, input logic [1:0] old_src);
        return (new_src != SRC_NONE) && (new_src >= old_src);
    endfunction

endpackage

// File: rtl/fetch_ctrl_redirect_buf.sv
// Pending-redirect register: remembers the strongest redirect seen while a read is outstanding.
// Only exception-capable when FETCH_CTRL_EXC_EN is defined (the top never presents SRC_EXC otherwise).
module redirect_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  new_src,
    input  logic [31:0] new_target,
    input  logic        capture,
    input  logic        clear,
    output logic        pend_valid,
    output logic [1:0]  pend_src,
    output logic [31:0] pend_target
);

    redir_src_t  src_q;
    logic [31:0] target_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q    <= SRC_NONE;
            target_q <= '0;
        end else if (clear) begin
            src_q    <= SRC_NONE;
            target_q <= '0;
        end else if (capture && takes_over(new_src, src_q)) begin
            src_q    <= redir_src_t'(new_src);
            target_q <= new_target;
        end
    end

    assign pend_valid  = (src_q != SRC_NONE);
    assign pend_src    = src_q;
    assign pend_target = target_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: drives the PC register, issues imem reads and feeds IF/ID.
// Define FETCH_CTRL_EXC_EN to add the exc_req/exc_target ports and the exception redirect level.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_enable,
    output logic        pc_load,
    output logic [31:0] pc_next,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
`ifdef FETCH_CTRL_EXC_EN
    input  logic        exc_req,
    input  logic [31:0] exc_target,
`endif
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_req,
    input  logic [31:0] jmp_target,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        flush
);

    fetch_state_t state;
    logic [31:0]  hold_inst;

    redir_src_t   new_src;
    logic [31:0]  new_target;
    logic         pend_valid;
    logic [1:0]   pend_src;
    logic [31:0]  pend_target;
    logic         win_valid;
    logic [31:0]  win_target;
    logic         capture;
    logic         clear;

    // Same-cycle winner: later assignments are higher priority.
    always_comb begin
        new_src    = SRC_NONE;
        new_target = '0;
        if (jmp_req) begin
            new_src    = SRC_JMP;
            new_target = jmp_target;
        end
        if (br_taken) begin
            new_src    = SRC_BR;
            new_target = br_target;
        end
`ifdef FETCH_CTRL_EXC_EN
        if (exc_req) begin
            new_src    = SRC_EXC;
            new_target = exc_target;
        end
`endif
    end

    // A fresh request that outranks (or ties) the pending entry wins this cycle.
    always_comb begin
        win_valid  = pend_valid;
        win_target = pend_target;
        if (takes_over(new_src, pend_src)) begin
            win_valid  = 1'b1;
            win_target = new_target;
        end
    end

    redirect_buf u_redirect_buf (
        .clk         (clk),
        .rst         (rst),
        .new_src     (new_src),
        .new_target  (new_target),
        .capture     (capture),
        .clear       (clear),
        .pend_valid  (pend_valid),
        .pend_src    (pend_src),
        .pend_target (pend_target)
    );

    // PC and memory controls are combinational so a redirect lands in the same cycle it is applied.
    always_comb begin
        pc_enable = 1'b0;
        pc_load   = 1'b0;
        pc_next   = '0;
        imem_req  = 1'b0;
        capture   = 1'b0;
        clear     = 1'b0;
        unique case (state)
            ST_BOOT: begin
                pc_enable = 1'b1;
                pc_load   = 1'b1;
                pc_next   = RESET_VECTOR;
                clear     = 1'b1;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (!imem_ready) begin
                    capture = 1'b1;
                end else if (win_valid) begin
                    pc_enable = 1'b1;
                    pc_load   = 1'b1;
                    pc_next   = win_target;
                    clear     = 1'b1;
                end else if (!stall) begin
                    pc_enable = 1'b1;
                end
            end
            ST_HOLD: begin
                if (win_valid) begin
                    pc_enable = 1'b1;
                    pc_load   = 1'b1;
                    pc_next   = win_target;
                    clear     = 1'b1;
                end else if (!stall) begin
                    pc_enable = 1'b1;
                end
            end
            default: begin
                pc_enable = 1'b0;
            end
        endcase
    end

    // The PC is frozen in HOLD, so the live pc is still the address of the buffered word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_BOOT;
            if_valid  <= 1'b0;
            if_inst   <= '0;
            if_pc     <= '0;
            flush     <= 1'b0;
            hold_inst <= '0;
        end else begin
            if_valid <= 1'b0;
            flush    <= 1'b0;
            case (state)
                ST_BOOT: begin
                    state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ready) begin
                        if (win_valid) begin
                            flush <= 1'b1;
                        end else if (stall) begin
                            hold_inst <= imem_rdata;
                            state     <= ST_HOLD;
                        end else begin
                            if_valid <= 1'b1;
                            if_inst  <= imem_rdata;
                            if_pc    <= pc;
                        end
                    end
                end
                ST_HOLD: begin
                    if (win_valid) begin
                        flush <= 1'b1;
                        state <= ST_FETCH;
                    end else if (!stall) begin
                        if_valid <= 1'b1;
                        if_inst  <= hold_inst;
                        if_pc    <= pc;
                        state    <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural PC register and a pc-keyed instruction memory.
// Exception vectors are exercised only when FETCH_CTRL_EXC_EN is defined.
module tb_fetch_ctrl;

    localparam logic [31:0] RV      = 32'hBFC0_0000;
    localparam logic [31:0] MEM_KEY = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc  = '0;
    logic        pc_enable, pc_load, imem_req;
    logic [31:0] pc_next;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        br_taken, jmp_req;
    logic [31:0] br_target, jmp_target;
    logic        if_valid, flush;
    logic [31:0] if_inst, if_pc;
`ifdef FETCH_CTRL_EXC_EN
    logic        exc_req    = 1'b0;
    logic [31:0] exc_target = '0;
    localparam logic [31:0] T3 = 32'h8000_0180;
`else
    localparam logic [31:0] T3 = 32'h0000_0200;
`endif

    int check_count = 0;
    int error_count = 0;

    fetch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .pc_enable  (pc_enable),
        .pc_load    (pc_load),
        .pc_next    (pc_next),
        .imem_req   (imem_req),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .stall      (stall),
`ifdef FETCH_CTRL_EXC_EN
        .exc_req    (exc_req),
        .exc_target (exc_target),
`endif
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp_req    (jmp_req),
        .jmp_target (jmp_target),
        .if_valid   (if_valid),
        .if_inst    (if_inst),
        .if_pc      (if_pc),
        .flush      (flush)
    );

    always #5 clk = ~clk;

    assign imem_rdata = pc ^ MEM_KEY;

    always @(posedge clk) begin
        if (pc_enable) pc <= pc_load ? pc_next : pc + 32'd4;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic stl, input logic br, input logic [31:0] br_t,
                                 input logic jmp, input logic [31:0] jmp_t);
        imem_ready = rdy;
        stall      = stl;
        br_taken   = br;
        br_target  = br_t;
        jmp_req    = jmp;
        jmp_target = jmp_t;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        tick();
        tick();
        checkOutput("rst_pc_enable", pc_enable, 1);
        checkOutput("rst_pc_load", pc_load, 1);
        checkOutput("rst_pc_next", pc_next, RV);
        checkOutput("rst_imem_req", imem_req, 0);
        checkOutput("rst_if_valid", if_valid, 0);
        checkOutput("rst_if_inst", if_inst, 0);
        checkOutput("rst_if_pc", if_pc, 0);
        checkOutput("rst_flush", flush, 0);

        rst = 1'b1;
        #1;
        checkOutput("boot_pc_load", pc_load, 1);
        checkOutput("boot_pc_next", pc_next, RV);
        checkOutput("boot_imem_req", imem_req, 0);
        tick();
        checkOutput("c2_imem_req", imem_req, 1);
        checkOutput("c2_pc_load", pc_load, 0);
        checkOutput("c2_pc", pc, RV);
        tick();
        checkOutput("seq0_valid", if_valid, 1);
        checkOutput("seq0_pc", if_pc, RV);
        checkOutput("seq0_inst", if_inst, RV ^ MEM_KEY);
        tick();
        checkOutput("seq1_pc", if_pc, RV + 32'd4);
        checkOutput("seq1_valid", if_valid, 1);
        tick();
        checkOutput("seq2_pc", if_pc, RV + 32'd8);

        // Branch arrives in the first of three wait cycles
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, '0);
        #1;
        checkOutput("wait_pc_enable", pc_enable, 0);
        tick();
        checkOutput("wait_if_valid", if_valid, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        tick();
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        #1;
        checkOutput("br_pc_load", pc_load, 1);
        checkOutput("br_pc_next", pc_next, 32'h0000_0100);
        tick();
        checkOutput("br_flush", flush, 1);
        checkOutput("br_drop", if_valid, 0);
        checkOutput("br_pc", pc, 32'h0000_0100);
        tick();
        checkOutput("br_if_pc", if_pc, 32'h0000_0100);
        checkOutput("br_if_valid", if_valid, 1);
        checkOutput("br_flush_end", flush, 0);

        // Pending jump superseded by a later exception when exceptions are built
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h0000_0200);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
`ifdef FETCH_CTRL_EXC_EN
        exc_req    = 1'b1;
        exc_target = 32'h8000_0180;
`endif
        tick();
`ifdef FETCH_CTRL_EXC_EN
        exc_req = 1'b0;
`endif
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        #1;
        checkOutput("exc_pc_next", pc_next, T3);
        tick();
        checkOutput("exc_flush", flush, 1);
        checkOutput("exc_pc", pc, T3);
        tick();
        checkOutput("exc_if_pc", if_pc, T3);

        // Newer branch replaces older branch; a later jump is ignored
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0500, 1'b0, '0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0600, 1'b0, '0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h0000_0800);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        #1;
        checkOutput("prio_pc_next", pc_next, 32'h0000_0600);
        tick();
        tick();
        checkOutput("prio_if_pc", if_pc, 32'h0000_0600);

        // Same-cycle branch outranks a pending jump
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h0000_0200);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0900, 1'b0, '0);
        #1;
        checkOutput("same_pc_next", pc_next, 32'h0000_0900);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        checkOutput("same_flush", flush, 1);
        tick();
        checkOutput("same_if_pc", if_pc, 32'h0000_0900);

        // Stall on the word at 0x40
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1, 32'h0000_0040);
        #1;
        checkOutput("jmp40_pc_next", pc_next, 32'h0000_0040);
        tick();
        checkOutput("jmp40_flush", flush, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        #1;
        checkOutput("stall_pc_enable", pc_enable, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("hold_if_valid", if_valid, 0);
            checkOutput("hold_imem_req", imem_req, 0);
            checkOutput("hold_pc", pc, 32'h0000_0040);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        #1;
        checkOutput("release_pc_enable", pc_enable, 1);
        checkOutput("release_pc_load", pc_load, 0);
        tick();
        checkOutput("release_if_valid", if_valid, 1);
        checkOutput("release_if_pc", if_pc, 32'h0000_0040);
        checkOutput("release_if_inst", if_inst, 32'h0000_0040 ^ MEM_KEY);
        checkOutput("release_pc", pc, 32'h0000_0044);
        checkOutput("release_imem_req", imem_req, 1);
        tick();
        checkOutput("next_if_pc", if_pc, 32'h0000_0044);

        // Branch while held: buffer discarded
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        tick();
        checkOutput("hold2_if_valid", if_valid, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0300, 1'b0, '0);
        #1;
        checkOutput("hold_br_pc_load", pc_load, 1);
        checkOutput("hold_br_pc_next", pc_next, 32'h0000_0300);
        tick();
        checkOutput("hold_br_flush", flush, 1);
        checkOutput("hold_br_if_valid", if_valid, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        tick();
        checkOutput("hold_br_if_pc", if_pc, 32'h0000_0300);
        checkOutput("hold_br_valid", if_valid, 1);

        // Reset during an outstanding read
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_if_valid", if_valid, 0);
        checkOutput("mid_rst_if_pc", if_pc, 0);
        checkOutput("mid_rst_flush", flush, 0);
        checkOutput("mid_rst_pc_next", pc_next, RV);
        checkOutput("mid_rst_imem_req", imem_req, 0);
        tick();
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        tick();
        checkOutput("restart_imem_req", imem_req, 1);
        checkOutput("restart_pc", pc, RV);
        tick();
        checkOutput("restart_if_pc", if_pc, RV);
        checkOutput("restart_if_valid", if_valid, 1);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
